timekeeper_core: RTL and testbench
==================================

# timekeeper_core

Parametrised successor to the clock's hours/minutes counter. Keeps full HH:MM:SS time in 24-hour internal form and counts seconds from a configurable clock prescaler. Adds a valid/ready load handshake with range checking, a run/stop control, 12/24-hour display mode, and registered carry pulses for downstream alarm and display blocks. Sits between the clock-domain tick source and the display/alarm logic of the digital clock.

## Interface
- TICKS_PER_SEC, default 1: clk cycles per second; legal range ≥1. Prescaler width is $clog2(TICKS_PER_SEC), minimum 1 bit.
- HOURS_PER_DAY, default 24: hour wrap modulus; legal values are 12 or 24. With 12, only mode12=0 display is defined.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  1 = count time, 0 = hold time and prescaler
- mode12  in  1  display select: 0 = 24 h, 1 = 12 h with o_pm
- load_valid  in  1  load request; held with data until accepted
- load_ready  out  1  block can accept a load this cycle
- load_hours  in  5  load value, 0..HOURS_PER_DAY-1
- load_minutes  in  6  load value, 0..59
- load_seconds  in  6  load value, 0..59
- load_err  out  1  one-cycle pulse: the accepted load was out of range and was discarded
- o_hours  out  5  displayed hours (format per mode12)
- o_minutes  out  6  minutes 0..59
- o_seconds  out  6  seconds 0..59
- o_pm  out  1  1 when internal hours ≥12; 0 in 24 h mode
- sec_tick  out  1  one-cycle pulse on every seconds advance
- min_tick  out  1  one-cycle pulse when seconds wrap 59→0
- day_tick  out  1  one-cycle pulse when time wraps to 00:00:00

## Operation
- Internal registers: h24 (5 b), m (6 b), s (6 b), presc.
- FSM has two states:
  - READY: load_ready=1.
  - COMMIT: load_ready=0 for exactly one cycle after an accept, then the FSM returns to READY.
- Accept condition: load_valid & load_ready.
- On accept, load fields are range-checked.
  - All fields legal: h24/m/s take the load values on that edge, presc clears to 0, and no tick pulses are emitted that cycle.
  - Any field illegal: the time is unchanged, presc is unchanged, and load_err pulses on the next cycle.
  - Either way the FSM enters COMMIT.
- Counting (run=1, no accept this cycle):
  - presc increments each cycle.
  - When presc==TICKS_PER_SEC-1, presc goes to 0 and time advances one second.
- Second advance:
  - s increments. At s==59, s goes to 0 and m increments.
  - At m==59, m goes to 0 and h24 increments.
  - At h24==HOURS_PER_DAY-1, h24 goes to 0.
- run=0: presc and time hold. Loads are still accepted.
- Priority: rst > accepted load > second advance. A load accepted on the same cycle as a prescaler wrap discards that second.
- Display mapping from h24, combinational:
  - mode12=0: o_hours = h24 and o_pm = 0.
  - mode12=1: h24==0 gives 12; 1..12 passes through unchanged; 13..23 gives h24-12. o_pm = (h24 ≥ 12).
- Arithmetic: all counters compare against exact terminal values. Illegal register values (unreachable after reset) must still wrap to 0 on the next advance.

## Timing
- Reset, on the rising edge with rst=1:
  - h24, m, s, presc = 0 and FSM = READY.
  - load_ready=1.
  - load_err, sec_tick, min_tick, day_tick = 0.
  - Outputs show 00:00:00 with o_pm=0; with mode12=1 they show 12:00:00.
- rst asserted during COMMIT or during a pending load: the load is dropped and the block starts clean.
- Time outputs and tick pulses are registered. A tick pulse is high in the same cycle the updated time first appears on the outputs.
- Advance latency: the second advance is visible one cycle after the clk edge on which presc==TICKS_PER_SEC-1 with run=1.
- Load latency: new time is visible on the cycle after the accept edge. load_err follows the same one-cycle latency.
- Multiple tick pulses coincide: at 23:59:59→00:00:00, sec_tick, min_tick and day_tick are all high in the same cycle.
- Back-to-back loads: at most one accept per two cycles, because COMMIT forces a one-cycle gap.
- mode12 changes take effect on o_hours/o_pm in the same cycle, without a clock edge.
- With TICKS_PER_SEC=1 and run=1, time advances every cycle.

## Test plan
- Reset then run, TICKS_PER_SEC=4, run=1 for 8 cycles -> o_seconds reaches 2. sec_tick pulses every 4th cycle. Prescaler phase is checked after deasserting run for 3 cycles: the next tick arrives exactly one full period later.
- Load 23:59:58 and run -> after 2 seconds the outputs read 00:00:00 and sec/min/day_tick pulse together in the same cycle.
- Load 24:00:00 or 10:60:00 -> load_err pulses once, time is unchanged, and load_ready is low for exactly one cycle.
- Load held valid for 4 cycles -> accepts occur on cycles 0 and 2 (two loads), with load_ready toggling 1,0,1,0.
- Load accepted on a prescaler-wrap cycle -> the loaded value appears with no increment and no sec_tick; the next second follows after a full TICKS_PER_SEC cycles.
- mode12=1 with h24 set to 0, 12 and 13 -> o_hours/o_pm read 12/0, 12/1 and 1/1. Asserting rst mid-count returns the block to 12:00:00, o_pm=0.

Source files
------------

// File: rtl/timekeeper_core.sv
// timekeeper_core: HH:MM:SS time base with prescaler, run/stop control,
// range-checked valid/ready loading, 12/24 h display mapping and carry pulses.
module timekeeper_core #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode12,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic       load_err,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;
  localparam logic [HW-1:0] H_TERM  = HW'(HOURS_PER_DAY - 1);
  localparam logic [MW-1:0] MS_TERM = MW'(59);
  localparam logic [MW-1:0] MS_MOD  = MW'(60);
  localparam logic [HW-1:0] NOON    = HW'(12);

  typedef enum logic {
    READY  = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t         state;
  logic [HW-1:0]  h24;
  logic [MW-1:0]  m;
  logic [MW-1:0]  s;
  logic [PW-1:0]  presc;

  logic accept;
  logic load_ok;
  logic presc_wrap;
  logic s_wrap;
  logic m_wrap;
  logic h_wrap;
  logic advance;

  // Handshake, range check and terminal-count decodes; out-of-range values
  // compare as terminal so they fall back to zero on the next advance.
  always_comb begin
    accept     = load_valid & load_ready;
    load_ok    = (32'(load_hours) < HOURS_PER_DAY) &&
                 (load_minutes < MS_MOD) && (load_seconds < MS_MOD);
    presc_wrap = (32'(presc) + 32'd1) >= TICKS_PER_SEC;
    s_wrap     = s >= MS_TERM;
    m_wrap     = m >= MS_TERM;
    h_wrap     = h24 >= H_TERM;
    advance    = run & ~accept & presc_wrap;
  end

  // Load handshake FSM: every accept is followed by one not-ready cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= READY;
      load_ready <= 1'b1;
    end else begin
      case (state)
        READY: begin
          if (accept) begin
            state      <= COMMIT;
            load_ready <= 1'b0;
          end
        end
        COMMIT: begin
          state      <= READY;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= READY;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  // Time registers and carry pulses; an accepted load overrides any advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      h24      <= '0;
      m        <= '0;
      s        <= '0;
      presc    <= '0;
      load_err <= 1'b0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      load_err <= 1'b0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      day_tick <= 1'b0;
      if (accept) begin
        if (load_ok) begin
          h24   <= load_hours;
          m     <= load_minutes;
          s     <= load_seconds;
          presc <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run) begin
        presc <= presc_wrap ? '0 : presc + PW'(1);
        if (advance) begin
          sec_tick <= 1'b1;
          if (s_wrap) begin
            s        <= '0;
            min_tick <= 1'b1;
            if (m_wrap) begin
              m <= '0;
              if (h_wrap) begin
                h24      <= '0;
                day_tick <= 1'b1;
              end else begin
                h24 <= h24 + HW'(1);
              end
            end else begin
              m <= m + MW'(1);
            end
          end else begin
            s <= s + MW'(1);
          end
        end
      end
    end
  end

  // Display mapping follows mode12 immediately, without waiting for a clock.
  always_comb begin
    o_hours = h24;
    o_pm    = 1'b0;
    if (mode12) begin
      o_pm = (h24 >= NOON);
      if (h24 == '0) begin
        o_hours = NOON;
      end else if (h24 > NOON) begin
        o_hours = h24 - NOON;
      end
    end
  end

  assign o_minutes = m;
  assign o_seconds = s;

endmodule

// File: tb/tb_timekeeper_core.sv
// Table-driven scoreboard bench for timekeeper_core with a 4-cycle prescaler.
module tb_timekeeper_core;

  localparam int unsigned TPS = 4;

  typedef struct packed {
    logic       rdy;
    logic       err;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       pm;
    logic       st;
    logic       mt;
    logic       dt;
  } obs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic       mode12;
    logic       lv;
    logic [4:0] lh;
    logic [5:0] lm;
    logic [5:0] ls;
    obs_t       exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       run;
  logic       mode12;
  logic       load_valid;
  logic       load_ready;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       load_err;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic       o_pm;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;

  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[$];
  obs_t exp_q[$];
  string name_q[$];
  int   row_q[$];
  obs_t mon_e;
  obs_t mon_a;
  string mon_n;
  int   mon_r;

  timekeeper_core #(.TICKS_PER_SEC(TPS), .HOURS_PER_DAY(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mode12       (mode12),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds),
    .load_err     (load_err),
    .o_hours      (o_hours),
    .o_minutes    (o_minutes),
    .o_seconds    (o_seconds),
    .o_pm         (o_pm),
    .sec_tick     (sec_tick),
    .min_tick     (min_tick),
    .day_tick     (day_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic add(input string nm, input logic r, input logic rn, input logic m12,
                     input logic lv, input int lh, input int lm, input int ls,
                     input logic rdy, input logic err, input int hh, input int mm,
                     input int ss, input logic pm, input logic st, input logic mt,
                     input logic dt);
    vec_t v;
    v.name   = nm;
    v.rst    = r;
    v.run    = rn;
    v.mode12 = m12;
    v.lv     = lv;
    v.lh     = 5'(lh);
    v.lm     = 6'(lm);
    v.ls     = 6'(ls);
    v.exp    = '{rdy: rdy, err: err, hh: 5'(hh), mm: 6'(mm), ss: 6'(ss),
                 pm: pm, st: st, mt: mt, dt: dt};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Scoreboard monitor: compare each queued expectation just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_r = row_q.pop_front();
      mon_a = {load_ready, load_err, o_hours, o_minutes, o_seconds,
               o_pm, sec_tick, min_tick, day_tick};
      checks++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL %s row %0d: got rdy=%b err=%b %0d:%0d:%0d pm=%b ticks=%b%b%b, want rdy=%b err=%b %0d:%0d:%0d pm=%b ticks=%b%b%b",
                 mon_n, mon_r, mon_a.rdy, mon_a.err, mon_a.hh, mon_a.mm, mon_a.ss,
                 mon_a.pm, mon_a.st, mon_a.mt, mon_a.dt,
                 mon_e.rdy, mon_e.err, mon_e.hh, mon_e.mm, mon_e.ss,
                 mon_e.pm, mon_e.st, mon_e.mt, mon_e.dt);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    run          = 1'b0;
    mode12       = 1'b0;
    load_valid   = 1'b0;
    load_hours   = '0;
    load_minutes = '0;
    load_seconds = '0;

    // Reset values in both display modes
    add("rst24", 1,0,0, 0,0,0,0,  1,0, 0,0,0, 0, 0,0,0);
    add("rst12", 1,0,1, 0,0,0,0,  1,0,12,0,0, 0, 0,0,0);
    // Counting: one second every TPS cycles
    for (int i = 1; i <= 8; i++)
      add("run", 0,1,0, 0,0,0,0,  1,0, 0,0,i/4, 0, ((i % 4) == 0),0,0);
    for (int i = 0; i < 3; i++) add("hold", 0,0,0, 0,0,0,0,  1,0, 0,0,2, 0, 0,0,0);
    for (int i = 0; i < 2; i++) add("phase", 0,1,0, 0,0,0,0,  1,0, 0,0,2, 0, 0,0,0);
    for (int i = 0; i < 3; i++) add("hold2", 0,0,0, 0,0,0,0,  1,0, 0,0,2, 0, 0,0,0);
    add("phase_pre", 0,1,0, 0,0,0,0,  1,0, 0,0,2, 0, 0,0,0);
    add("phase_tick",0,1,0, 0,0,0,0,  1,0, 0,0,3, 0, 1,0,0);
    // Day wrap from 23:59:58
    add("ld235958", 0,1,0, 1,23,59,58,  0,0,23,59,58, 0, 0,0,0);
    for (int i = 0; i < 3; i++) add("wrap_a", 0,1,0, 0,0,0,0,  1,0,23,59,58, 0, 0,0,0);
    add("wrap_s59", 0,1,0, 0,0,0,0,  1,0,23,59,59, 0, 1,0,0);
    for (int i = 0; i < 3; i++) add("wrap_b", 0,1,0, 0,0,0,0,  1,0,23,59,59, 0, 0,0,0);
    add("wrap_day", 0,1,0, 0,0,0,0,  1,0, 0, 0, 0, 0, 1,1,1);
    // Illegal loads: error pulse, nothing else changes (prescaler included)
    add("bad_h",  0,0,0, 1,24,0,0,  0,1, 0,0,0, 0, 0,0,0);
    add("bad_gap",0,0,0, 0,0,0,0,   1,0, 0,0,0, 0, 0,0,0);
    add("bad_m",  0,1,0, 1,10,60,0, 0,1, 0,0,0, 0, 0,0,0);
    for (int i = 0; i < 3; i++) add("bad_presc", 0,1,0, 0,0,0,0,  1,0, 0,0,0, 0, 0,0,0);
    add("bad_tick", 0,1,0, 0,0,0,0,  1,0, 0,0,1, 0, 1,0,0);
    // Load held valid: accepts on alternate cycles only
    add("hold_ld1", 0,0,0, 1,5,6,7,  0,0,5,6,7, 0, 0,0,0);
    add("hold_ld2", 0,0,0, 1,6,7,8,  1,0,5,6,7, 0, 0,0,0);
    add("hold_ld3", 0,0,0, 1,6,7,8,  0,0,6,7,8, 0, 0,0,0);
    add("hold_ld4", 0,0,0, 1,7,8,9,  1,0,6,7,8, 0, 0,0,0);
    add("hold_ld5", 0,0,0, 1,7,8,9,  0,0,7,8,9, 0, 0,0,0);
    add("hold_gap", 0,0,0, 0,0,0,0,  1,0,7,8,9, 0, 0,0,0);
    // Load on the prescaler-wrap cycle discards that second
    for (int i = 0; i < 3; i++) add("pre_wrap", 0,1,0, 0,0,0,0,  1,0,7,8,9, 0, 0,0,0);
    add("ld_on_wrap", 0,1,0, 1,12,34,56,  0,0,12,34,56, 0, 0,0,0);
    for (int i = 0; i < 3; i++) add("post_ld", 0,1,0, 0,0,0,0,  1,0,12,34,56, 0, 0,0,0);
    add("post_tick", 0,1,0, 0,0,0,0,  1,0,12,34,57, 0, 1,0,0);
    // Minute carry into the hour without a day wrap
    add("ld105959", 0,1,0, 1,10,59,59,  0,0,10,59,59, 0, 0,0,0);
    for (int i = 0; i < 3; i++) add("carry_pre", 0,1,0, 0,0,0,0,  1,0,10,59,59, 0, 0,0,0);
    add("min_carry", 0,1,0, 0,0,0,0,  1,0,11,0,0, 0, 1,1,0);
    // 12 h display mapping
    add("m12_h0",   0,0,1, 1,0,0,0,   0,0,12,0,0, 0, 0,0,0);
    add("m12_gap0", 0,0,1, 0,0,0,0,   1,0,12,0,0, 0, 0,0,0);
    add("m12_h12",  0,0,1, 1,12,0,0,  0,0,12,0,0, 1, 0,0,0);
    add("m12_gap1", 0,0,1, 0,0,0,0,   1,0,12,0,0, 1, 0,0,0);
    add("m12_h13",  0,0,1, 1,13,0,0,  0,0, 1,0,0, 1, 0,0,0);
    add("m12_gap2", 0,0,1, 0,0,0,0,   1,0, 1,0,0, 1, 0,0,0);
    // Reset during COMMIT with another load pending
    add("ld135959",   0,1,1, 1,13,59,59,  0,0, 1,59,59, 1, 0,0,0);
    add("rst_commit", 1,1,1, 1,5,0,0,     1,0,12,0,0,   0, 0,0,0);
    add("after_rst",  0,0,1, 0,0,0,0,     1,0,12,0,0,   0, 0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      run          = vecs[i].run;
      mode12       = vecs[i].mode12;
      load_valid   = vecs[i].lv;
      load_hours   = vecs[i].lh;
      load_minutes = vecs[i].lm;
      load_seconds = vecs[i].ls;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      row_q.push_back(i);
    end

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    // mode12 switches the hour display with no clock edge in between
    @(negedge clk);
    rst          = 1'b0;
    run          = 1'b0;
    mode12       = 1'b0;
    load_valid   = 1'b1;
    load_hours   = 5'd13;
    load_minutes = 6'd45;
    load_seconds = 6'd0;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("comb_h24", int'(o_hours), 13);
    check("comb_min", int'(o_minutes), 45);
    mode12 = 1'b1;
    #1;
    check("comb_h12", int'(o_hours), 1);
    check("comb_pm12", int'(o_pm), 1);
    mode12 = 1'b0;
    #1;
    check("comb_h24b", int'(o_hours), 13);
    check("comb_pm24", int'(o_pm), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
